// File: rtl/usb_hid_mouse_device_ep_if.sv
// ---------------------------------------------------------------------------
// usb_hid_mouse_device_ep_if
// Link between the device protocol layer and the HID mouse IN endpoint.
// Carries the decoded token and host handshake toward the endpoint, and the
// packet transmit bus (start/PID, payload byte stream, done) back out.
//   master : protocol layer (drives tokens, ACK, tx_data_ready, tx_done)
//   slave  : endpoint       (drives tx_start, tx_pid, tx_data, tx_data_valid,
//                            tx_last)
// ---------------------------------------------------------------------------
interface usb_hid_mouse_device_ep_if;
    logic       token_in_valid;
    logic [6:0] token_addr;
    logic [3:0] token_endp;
    logic       host_ack;
    logic       tx_start;
    logic [3:0] tx_pid;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_data_ready;
    logic       tx_last;
    logic       tx_done;

    modport master (
        output token_in_valid, token_addr, token_endp, host_ack,
        output tx_data_ready, tx_done,
        input  tx_start, tx_pid, tx_data, tx_data_valid, tx_last
    );

    modport slave (
        input  token_in_valid, token_addr, token_endp, host_ack,
        input  tx_data_ready, tx_done,
        output tx_start, tx_pid, tx_data, tx_data_valid, tx_last
    );
endinterface

// File: rtl/usb_hid_mouse_device_ep.sv
// ---------------------------------------------------------------------------
// usb_hid_mouse_device_ep
// Device-side HID boot-mouse interrupt IN endpoint. Accumulates motion and
// button state from a local source and answers host IN tokens with a
// DATA0/DATA1 report, NAK (nothing new) or STALL (halted). A report stays
// pending until the host ACKs it; unacked reports are resent unchanged.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   enable              endpoint configured; low clears all endpoint state
//   dev_addr            assigned device address
//   set_halt/clear_halt halt control pulses (set wins)
//   move_valid, move_dx/dy/wheel  signed motion sample
//   buttons             current button levels
//   bus (slave)         token/handshake in, packet transmit out
//   halted, data_pid, retry_count  status
//   idle_rate           only with HID_IDLE_RATE_EN: HID idle period, 4 ms units
//
// Optional feature macro: HID_IDLE_RATE_EN (periodic resend of an unchanged
// report after idle_rate * 4 ms without a commit).
// ---------------------------------------------------------------------------
module usb_hid_mouse_device_ep #(
    parameter int DEV_EP      = 1,
    parameter int ACK_TIMEOUT = 1000,
    parameter int REPORT_LEN  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [6:0]  dev_addr,
    input  logic        set_halt,
    input  logic        clear_halt,
    input  logic        move_valid,
    input  logic [7:0]  move_dx,
    input  logic [7:0]  move_dy,
    input  logic [7:0]  move_wheel,
    input  logic [7:0]  buttons,
`ifdef HID_IDLE_RATE_EN
    input  logic [7:0]  idle_rate,
`endif
    usb_hid_mouse_device_ep_if.slave bus,
    output logic        halted,
    output logic        data_pid,
    output logic [7:0]  retry_count
);
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;
    localparam int         ACK_W     = $clog2(ACK_TIMEOUT + 1);
    localparam logic [1:0] LAST_IDX  = 2'(REPORT_LEN - 1);

    typedef enum logic [2:0] {IDLE, SEND_HS, SEND_DATA, WAIT_DONE, WAIT_ACK} state_t;

    state_t                  state_reg;
    logic                    tx_start_reg;
    logic [3:0]              tx_pid_reg;
    logic [7:0]              tx_data_reg;
    logic                    tx_data_valid_reg;
    logic                    tx_last_reg;
    logic                    halted_reg;
    logic                    data_pid_reg;
    logic [7:0]              retry_count_reg;
    logic                    pending_reg;
    logic                    token_replay_reg;
    logic [1:0]              byte_idx_reg;
    logic [ACK_W-1:0]        ack_cnt_reg;
    logic [7:0]              last_buttons_reg;
    logic [7:0]              snap_buttons_reg;
    logic [7:0]              snap_axis_reg [3];
    logic signed [15:0]      acc_reg [3];

    logic signed [15:0]      acc_next [3];
    logic [7:0]              clamp_val [3];
    logic [2:0]              acc_nonzero;
    logic [7:0]              delta [3];
    logic                    token_match;
    logic                    clear_eff;
    logic                    halt_now;
    logic                    pending_now;
    logic                    data_pid_now;
    logic                    commit;
    logic                    dirty;
    logic                    idle_expired;
    logic [1:0]              next_idx;
    logic [7:0]              next_byte;

    assign delta[0] = move_dx;
    assign delta[1] = move_dy;
    assign delta[2] = move_wheel;

    assign token_match  = bus.token_in_valid && enable &&
                          bus.token_addr == dev_addr && bus.token_endp == 4'(DEV_EP);
    // set_halt wins over clear_halt; the "now" views let a token in the same
    // cycle as a halt pulse already see the new halt/toggle/pending state.
    assign clear_eff    = clear_halt && !set_halt;
    assign halt_now     = set_halt || (halted_reg && !clear_eff);
    assign pending_now  = pending_reg && !clear_eff;
    assign data_pid_now = data_pid_reg && !clear_eff;
    assign commit       = enable && state_reg == WAIT_ACK && bus.host_ack && pending_now;
    assign dirty        = (|acc_nonzero) || (buttons != last_buttons_reg) || idle_expired;

    // Per-axis saturating accumulate (with snapshot subtraction on commit)
    // and the +/-127 clamp used when a snapshot is taken.
    for (genvar gi = 0; gi < 3; gi++) begin : g_axis
        logic signed [16:0] sum;
        always_comb begin
            sum = {acc_reg[gi][15], acc_reg[gi]};
            if (commit)
                sum = sum - {{9{snap_axis_reg[gi][7]}}, snap_axis_reg[gi]};
            if (move_valid)
                sum = sum + {{9{delta[gi][7]}}, delta[gi]};
            if (sum > 17'sd32767)
                acc_next[gi] = 16'sh7FFF;
            else if (sum < -17'sd32768)
                acc_next[gi] = 16'sh8000;
            else
                acc_next[gi] = sum[15:0];

            if (acc_reg[gi] > 16'sd127)
                clamp_val[gi] = 8'h7F;
            else if (acc_reg[gi] < -16'sd127)
                clamp_val[gi] = 8'h81;
            else
                clamp_val[gi] = acc_reg[gi][7:0];
        end
        assign acc_nonzero[gi] = acc_reg[gi] != 16'sd0;
    end

    assign next_idx = byte_idx_reg + 2'd1;
    always_comb begin
        next_byte = snap_buttons_reg;
        case (next_idx)
            2'd1:    next_byte = snap_axis_reg[0];
            2'd2:    next_byte = snap_axis_reg[1];
            2'd3:    next_byte = snap_axis_reg[2];
            default: next_byte = snap_buttons_reg;
        endcase
    end

`ifdef HID_IDLE_RATE_EN
    // One idle_rate unit is 4 ms = 240000 cycles at 60 MHz; 255 units fit 26 bits.
    logic [25:0] idle_cnt_reg;
    logic [25:0] idle_period;
    assign idle_period  = 26'(idle_rate) * 26'd240000;
    assign idle_expired = (idle_rate != 8'd0) && (idle_cnt_reg >= idle_period);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idle_cnt_reg <= '0;
        else if (!enable || commit)
            idle_cnt_reg <= '0;
        else if (!idle_expired)
            idle_cnt_reg <= idle_cnt_reg + 26'd1;
    end
`else
    assign idle_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                acc_reg[i]       <= '0;
                snap_axis_reg[i] <= '0;
            end
        end else if (!enable) begin
            for (int i = 0; i < 3; i++)
                acc_reg[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++)
                acc_reg[i] <= acc_next[i];
            if (state_reg == IDLE && (token_match || token_replay_reg) &&
                !halt_now && !pending_now && dirty) begin
                for (int i = 0; i < 3; i++)
                    snap_axis_reg[i] <= clamp_val[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            tx_start_reg      <= 1'b0;
            tx_pid_reg        <= 4'h0;
            tx_data_reg       <= 8'h00;
            tx_data_valid_reg <= 1'b0;
            tx_last_reg       <= 1'b0;
            halted_reg        <= 1'b0;
            data_pid_reg      <= 1'b0;
            retry_count_reg   <= 8'h00;
            pending_reg       <= 1'b0;
            token_replay_reg  <= 1'b0;
            byte_idx_reg      <= 2'd0;
            ack_cnt_reg       <= '0;
            last_buttons_reg  <= 8'h00;
            snap_buttons_reg  <= 8'h00;
        end else begin
            tx_start_reg <= 1'b0;
            halted_reg   <= halt_now;
            if (clear_eff) begin
                data_pid_reg <= 1'b0;
                pending_reg  <= 1'b0;
            end

            if (!enable) begin
                state_reg         <= IDLE;
                tx_pid_reg        <= 4'h0;
                tx_data_reg       <= 8'h00;
                tx_data_valid_reg <= 1'b0;
                tx_last_reg       <= 1'b0;
                pending_reg       <= 1'b0;
                data_pid_reg      <= 1'b0;
                last_buttons_reg  <= 8'h00;
                token_replay_reg  <= 1'b0;
                byte_idx_reg      <= 2'd0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        token_replay_reg <= 1'b0;
                        if (token_match || token_replay_reg) begin
                            tx_start_reg <= 1'b1;
                            byte_idx_reg <= 2'd0;
                            tx_last_reg  <= 1'b0;
                            if (halt_now) begin
                                tx_pid_reg <= PID_STALL;
                                state_reg  <= SEND_HS;
                            end else if (pending_now) begin
                                tx_pid_reg        <= data_pid_now ? PID_DATA1 : PID_DATA0;
                                tx_data_reg       <= snap_buttons_reg;
                                tx_data_valid_reg <= 1'b1;
                                state_reg         <= SEND_DATA;
                            end else if (dirty) begin
                                snap_buttons_reg  <= buttons;
                                pending_reg       <= 1'b1;
                                tx_pid_reg        <= data_pid_now ? PID_DATA1 : PID_DATA0;
                                tx_data_reg       <= buttons;
                                tx_data_valid_reg <= 1'b1;
                                state_reg         <= SEND_DATA;
                            end else begin
                                tx_pid_reg <= PID_NAK;
                                state_reg  <= SEND_HS;
                            end
                        end
                    end
                    SEND_HS: begin
                        if (bus.tx_done)
                            state_reg <= IDLE;
                    end
                    SEND_DATA: begin
                        if (tx_data_valid_reg && bus.tx_data_ready) begin
                            if (byte_idx_reg == LAST_IDX) begin
                                tx_data_valid_reg <= 1'b0;
                                tx_last_reg       <= 1'b0;
                                state_reg         <= WAIT_DONE;
                            end else begin
                                byte_idx_reg <= next_idx;
                                tx_data_reg  <= next_byte;
                                tx_last_reg  <= (next_idx == LAST_IDX);
                            end
                        end
                    end
                    WAIT_DONE: begin
                        if (bus.tx_done) begin
                            ack_cnt_reg <= '0;
                            state_reg   <= WAIT_ACK;
                        end
                    end
                    WAIT_ACK: begin
                        if (bus.host_ack) begin
                            if (commit) begin
                                data_pid_reg     <= ~data_pid_reg;
                                last_buttons_reg <= snap_buttons_reg;
                                pending_reg      <= 1'b0;
                            end
                            state_reg <= IDLE;
                        end else if (token_match || ack_cnt_reg >= ACK_W'(ACK_TIMEOUT - 1)) begin
                            // Give up on this ACK; the snapshot stays pending and a
                            // token that caused the abort is replayed from IDLE.
                            token_replay_reg <= token_match;
                            if (retry_count_reg != 8'hFF)
                                retry_count_reg <= retry_count_reg + 8'd1;
                            state_reg <= IDLE;
                        end else begin
                            ack_cnt_reg <= ack_cnt_reg + ACK_W'(1);
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign bus.tx_start      = tx_start_reg;
    assign bus.tx_pid        = tx_pid_reg;
    assign bus.tx_data       = tx_data_reg;
    assign bus.tx_data_valid = tx_data_valid_reg;
    assign bus.tx_last       = tx_last_reg;
    assign halted            = halted_reg;
    assign data_pid          = data_pid_reg;
    assign retry_count       = retry_count_reg;
endmodule

// File: tb/tb_usb_hid_mouse_device_ep.sv
module tb_usb_hid_mouse_device_ep;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [6:0] dev_addr = 7'h05;
    logic       set_halt = 1'b0;
    logic       clear_halt = 1'b0;
    logic       move_valid = 1'b0;
    logic [7:0] move_dx = 8'h00;
    logic [7:0] move_dy = 8'h00;
    logic [7:0] move_wheel = 8'h00;
    logic [7:0] buttons = 8'h00;
`ifdef HID_IDLE_RATE_EN
    logic [7:0] idle_rate = 8'h00;
`endif
    logic       halted;
    logic       data_pid;
    logic [7:0] retry_count;

    usb_hid_mouse_device_ep_if bus ();

    usb_hid_mouse_device_ep #(
        .DEV_EP      (1),
        .ACK_TIMEOUT (20),
        .REPORT_LEN  (4)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .dev_addr    (dev_addr),
        .set_halt    (set_halt),
        .clear_halt  (clear_halt),
        .move_valid  (move_valid),
        .move_dx     (move_dx),
        .move_dy     (move_dy),
        .move_wheel  (move_wheel),
        .buttons     (buttons),
`ifdef HID_IDLE_RATE_EN
        .idle_rate   (idle_rate),
`endif
        .bus         (bus),
        .halted      (halted),
        .data_pid    (data_pid),
        .retry_count (retry_count)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] rx_pid;
    logic [7:0] rx [4];
    int         rx_n;
    logic [3:0] rx_last_mask;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic move(input logic [7:0] dx, input logic [7:0] dy, input logic [7:0] w);
        move_valid = 1'b1; move_dx = dx; move_dy = dy; move_wheel = w;
        tick();
        move_valid = 1'b0; move_dx = 8'h00; move_dy = 8'h00; move_wheel = 8'h00;
    endtask

    task automatic token(input logic [6:0] addr, input logic [3:0] endp);
        bus.token_in_valid = 1'b1; bus.token_addr = addr; bus.token_endp = endp;
        tick();
        bus.token_in_valid = 1'b0;
    endtask

    task automatic ack();
        bus.host_ack = 1'b1;
        tick();
        bus.host_ack = 1'b0;
    endtask

    // Matching IN token, collect the packet (ready held high), then tx_done.
    task automatic do_in(input string tag);
        logic last_seen;
        token(dev_addr, 4'd1);
        check({tag, "_start"}, {31'd0, bus.tx_start}, 32'd1);
        rx_pid = bus.tx_pid;
        rx_n = 0;
        rx_last_mask = 4'b0000;
        last_seen = 1'b0;
        for (int i = 0; i < 8 && !last_seen; i++) begin
            if (bus.tx_data_valid) begin
                if (rx_n < 4) begin
                    rx[rx_n] = bus.tx_data;
                    rx_last_mask[rx_n] = bus.tx_last;
                end
                rx_n++;
                last_seen = bus.tx_last;
            end
            tick();
        end
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
    endtask

    task automatic expect_hs(input string tag, input logic [3:0] pid);
        do_in(tag);
        check({tag, "_pid"}, {28'd0, rx_pid}, {28'd0, pid});
        check({tag, "_nbytes"}, rx_n, 32'd0);
    endtask

    task automatic expect_report(input string tag, input logic [3:0] pid, input logic [31:0] bytes);
        do_in(tag);
        check({tag, "_pid"}, {28'd0, rx_pid}, {28'd0, pid});
        check({tag, "_nbytes"}, rx_n, 32'd4);
        check({tag, "_bytes"}, {rx[0], rx[1], rx[2], rx[3]}, bytes);
        check({tag, "_lastmask"}, {28'd0, rx_last_mask}, 32'h8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.token_in_valid = 1'b0;
        bus.token_addr     = 7'h00;
        bus.token_endp     = 4'h0;
        bus.host_ack       = 1'b0;
        bus.tx_data_ready  = 1'b1;
        bus.tx_done        = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_tx_start", {31'd0, bus.tx_start}, 32'd0);
        check("rst_tx_pid", {28'd0, bus.tx_pid}, 32'd0);
        check("rst_tx_valid", {31'd0, bus.tx_data_valid}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_data_pid", {31'd0, data_pid}, 32'd0);
        check("rst_retry", {24'd0, retry_count}, 32'd0);
        rst_n = 1'b1;
        enable = 1'b1;
        tick();

        // Non-matching tokens get no response
        token(7'h06, 4'd1);
        check("badaddr_start", {31'd0, bus.tx_start}, 32'd0);
        token(7'h05, 4'd2);
        check("badep_start", {31'd0, bus.tx_start}, 32'd0);

        // No motion -> NAK
        expect_hs("idle_nak", 4'hA);

        // Basic report
        buttons = 8'h01;
        move(8'd5, 8'hFD, 8'd1);
        expect_report("rep1", 4'h3, 32'h0105FD01);
        ack();
        check("rep1_toggle", {31'd0, data_pid}, 32'd1);
        expect_hs("rep1_nak", 4'hA);

        // Clamp and residual: 300 -> 127, 127, 46
        move(8'd100, 8'd0, 8'd0);
        move(8'd100, 8'd0, 8'd0);
        move(8'd100, 8'd0, 8'd0);
        expect_report("sat1", 4'hB, 32'h017F0000);
        ack();
        expect_report("sat2", 4'h3, 32'h017F0000);
        ack();
        expect_report("sat3", 4'hB, 32'h012E0000);
        ack();
        expect_hs("sat_nak", 4'hA);

        // ACK timeout -> identical retransmit, retry_count counts
        move(8'd3, 8'd0, 8'd0);
        expect_report("to_first", 4'h3, 32'h01030000);
        repeat (25) tick();
        check("to_retry", {24'd0, retry_count}, 32'd1);
        move(8'd2, 8'd0, 8'd0);
        expect_report("to_resend", 4'h3, 32'h01030000);
        ack();
        check("to_toggle", {31'd0, data_pid}, 32'd1);
        expect_report("to_next", 4'hB, 32'h01020000);
        ack();

        // Halt / clear halt
        move(8'd1, 8'd0, 8'd0);
        expect_report("pre_halt", 4'h3, 32'h01010000);
        ack();
        check("pre_halt_toggle", {31'd0, data_pid}, 32'd1);
        set_halt = 1'b1; tick(); set_halt = 1'b0;
        check("halt_set", {31'd0, halted}, 32'd1);
        expect_hs("halt_stall", 4'hE);
        clear_halt = 1'b1; tick(); clear_halt = 1'b0;
        check("halt_clr", {31'd0, halted}, 32'd0);
        check("halt_clr_pid", {31'd0, data_pid}, 32'd0);
        move(8'd1, 8'd0, 8'd0);
        expect_report("post_halt", 4'h3, 32'h01010000);
        ack();

        // Backpressure on byte 1
        move(8'd9, 8'd0, 8'd0);
        token(dev_addr, 4'd1);
        check("bp_start", {31'd0, bus.tx_start}, 32'd1);
        check("bp_pid", {28'd0, bus.tx_pid}, 32'hB);
        check("bp_b0", {24'd0, bus.tx_data}, 32'h01);
        tick();
        bus.tx_data_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_hold", {bus.tx_data_valid, bus.tx_last, bus.tx_data}, {2'b10, 8'h09});
            tick();
        end
        bus.tx_data_ready = 1'b1;
        check("bp_b1", {bus.tx_data_valid, bus.tx_last, bus.tx_data}, {2'b10, 8'h09});
        tick();
        check("bp_b2", {bus.tx_data_valid, bus.tx_last, bus.tx_data}, {2'b10, 8'h00});
        tick();
        check("bp_b3", {bus.tx_data_valid, bus.tx_last, bus.tx_data}, {2'b11, 8'h00});
        tick();
        check("bp_end_valid", {31'd0, bus.tx_data_valid}, 32'd0);
        bus.tx_done = 1'b1; tick(); bus.tx_done = 1'b0;
        ack();
        check("bp_toggle", {31'd0, data_pid}, 32'd0);

        // Disable mid-packet
        move(8'd4, 8'd0, 8'd0);
        token(dev_addr, 4'd1);
        check("dis_start", {31'd0, bus.tx_data_valid}, 32'd1);
        enable = 1'b0;
        tick();
        check("dis_outputs", {bus.tx_start, bus.tx_data_valid, bus.tx_last, bus.tx_pid}, 32'd0);
        buttons = 8'h00;
        enable = 1'b1;
        tick();
        expect_hs("dis_nak", 4'hA);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
